// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG ring-fill path: BRAM data/strobe widths,
// default ring geometry and the fill engine state encoding.
package trng_pkg;

  localparam int unsigned BRAM_DATA_W    = 32;
  localparam int unsigned BRAM_STRB_W    = 4;
  localparam logic [11:0] RING_BASE_DEF  = 12'h800;
  localparam int unsigned RING_DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } fill_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A tie goes to the requester holding
// priority; priority then passes to the loser so neither waits twice.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_prio;  // 0: requester 0 wins a tie

  // Grant decode from requests and current priority
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_prio ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  // Priority flips only on a tie, handing it to the requester that lost
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= 1'b0;
    end else if (i_req == 2'b11) begin
      r_prio <= ~r_prio;
    end else begin
      r_prio <= r_prio;
    end
  end

endmodule

// File: rtl/trng_bram_fill_arbiter.sv
// Shares BRAM port A between the AXI host path and a TRNG ring-fill engine,
// tracking ring pointer and fill level until software clears the ring.
module trng_bram_fill_arbiter
  import trng_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0]   RING_BASE  = ADDR_WIDTH'(RING_BASE_DEF),
  parameter int unsigned             RING_DEPTH = RING_DEPTH_DEF,
  localparam int unsigned            PTR_W      = $clog2(RING_DEPTH),
  localparam int unsigned            CNT_W      = PTR_W + 1
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic                   h_req,
  input  logic [BRAM_STRB_W-1:0] h_we,
  input  logic [ADDR_WIDTH-1:0]  h_addr,
  input  logic [BRAM_DATA_W-1:0] h_wrdata,
  output logic                   h_gnt,
  output logic [BRAM_DATA_W-1:0] h_rdata,
  output logic                   h_rvalid,
  input  logic [BRAM_DATA_W-1:0] rng_data,
  input  logic                   rng_valid,
  output logic                   rng_ready,
  input  logic                   fill_en,
  input  logic                   fill_clear,
  output logic [CNT_W-1:0]       fill_level,
  output logic                   fill_full,
  output logic                   bram_en,
  output logic [BRAM_STRB_W-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  output logic [BRAM_DATA_W-1:0] bram_wrdata,
  input  logic [BRAM_DATA_W-1:0] bram_rddata
);

  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(RING_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_LAST_C = CNT_W'(RING_DEPTH - 1);

  fill_state_t            r_state;
  fill_state_t            w_state_nxt;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic [CNT_W-1:0]       r_level;
  logic [CNT_W-1:0]       w_level_nxt;
  logic                   r_full;
  logic                   r_rvalid;
  logic                   w_f_req;
  logic [1:0]             w_gnt;
  logic                   w_h_gnt;
  logic                   w_f_gnt;
  logic [ADDR_WIDTH-1:0]  w_ring_addr;

  assign w_f_req = (r_state == FILL) & rng_valid & ~fill_clear;

  rr_arb2 u_arb (
    .i_clk   (s_axi_aclk),
    .i_rst_n (s_axi_aresetn),
    .i_req   ({w_f_req, h_req}),
    .o_gnt   (w_gnt)
  );

  // Grants are gated by reset so the BRAM port goes quiet the moment reset asserts
  assign w_h_gnt     = w_gnt[0] & s_axi_aresetn;
  assign w_f_gnt     = w_gnt[1] & s_axi_aresetn;
  assign w_ring_addr = RING_BASE + ADDR_WIDTH'({r_ptr, 2'b00});

  assign h_gnt      = w_h_gnt;
  assign rng_ready  = w_f_gnt;
  assign h_rdata    = bram_rddata;
  assign h_rvalid   = r_rvalid;
  assign fill_level = r_level;
  assign fill_full  = r_full;

  // BRAM port mux driven by whichever side holds the grant
  always_comb begin
    bram_en     = 1'b0;
    bram_we     = 4'h0;
    bram_addr   = {ADDR_WIDTH{1'b0}};
    bram_wrdata = 32'h0000_0000;
    if (w_h_gnt) begin
      bram_en     = 1'b1;
      bram_we     = h_we;
      bram_addr   = h_addr;
      bram_wrdata = h_wrdata;
    end else if (w_f_gnt) begin
      bram_en     = 1'b1;
      bram_we     = 4'hF;
      bram_addr   = w_ring_addr;
      bram_wrdata = rng_data;
    end else begin
      bram_en     = 1'b0;
    end
  end

  // Pointer/level update: clear wins, otherwise advance on each granted fill write
  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_level_nxt = r_level;
    if (fill_clear) begin
      w_ptr_nxt   = {PTR_W{1'b0}};
      w_level_nxt = {CNT_W{1'b0}};
    end else if (w_f_gnt) begin
      w_ptr_nxt   = r_ptr + 1'b1;
      w_level_nxt = r_level + 1'b1;
    end else begin
      w_ptr_nxt   = r_ptr;
      w_level_nxt = r_level;
    end
  end

  // Fill engine next-state
  always_comb begin
    w_state_nxt = r_state;
    if (fill_clear) begin
      w_state_nxt = fill_en ? FILL : IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (fill_en) w_state_nxt = (r_level == DEPTH_C) ? FULL : FILL;
          else         w_state_nxt = IDLE;
        end
        FILL: begin
          if (!fill_en)                                  w_state_nxt = IDLE;
          else if (w_f_gnt && (r_level == DEPTH_LAST_C)) w_state_nxt = FULL;
          else                                           w_state_nxt = FILL;
        end
        FULL: begin
          if (!fill_en) w_state_nxt = IDLE;
          else          w_state_nxt = FULL;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, ring bookkeeping and host read-valid pipe
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state  <= IDLE;
      r_ptr    <= {PTR_W{1'b0}};
      r_level  <= {CNT_W{1'b0}};
      r_full   <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == DEPTH_C);
      r_rvalid <= w_h_gnt & (h_we == 4'h0);
    end
  end

endmodule
